// File: rtl/add_operand_driver.sv
// Self-test sequencer for a combinational WIDTH-bit adder: sweeps every operand
// pair, waits SETTLE cycles, checks sum_in against a+b mod 2^WIDTH and keeps error stats.
module add_operand_driver #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   in1,
    output logic [WIDTH-1:0]   in2,
    input  logic [WIDTH-1:0]   sum_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               first_err_valid,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b,
    output logic [2:0]         dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   idx_q, idx_d;
    logic [2*WIDTH:0]     err_q, err_d;
    logic                 fev_q, fev_d;
    logic [WIDTH-1:0]     fea_q, fea_d;
    logic [WIDTH-1:0]     feb_q, feb_d;
    logic                 pass_q, pass_d;

    logic [WIDTH-1:0]     exp_sum;
    logic                 mismatch;

    // Pair index is {in1, in2}; in2 is the low half and therefore increments fastest.
    assign exp_sum  = idx_q[2*WIDTH-1:WIDTH] + idx_q[WIDTH-1:0];
    assign mismatch = (sum_in != exp_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fea_q   <= '0;
            feb_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fea_q   <= fea_d;
            feb_q   <= feb_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fea_d   = fea_q;
        feb_d   = feb_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    fev_d   = 1'b0;
                    fea_d   = '0;
                    feb_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                cnt_d   = SETTLE_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fea_d = idx_q[2*WIDTH-1:WIDTH];
                        feb_d = idx_q[WIDTH-1:0];
                    end
                end
                // pass is resolved here so it is already valid during the DONE cycle.
                if (&idx_q) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in1             = idx_q[2*WIDTH-1:WIDTH];
    assign in2             = idx_q[WIDTH-1:0];
    assign busy            = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done            = (state_q == S_DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_a     = fea_q;
    assign first_err_b     = feb_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_add_operand_driver.sv
// Directed bench for add_operand_driver: reset, good/faulty adders, mid-sweep reset,
// start handling, back-to-back sweeps and SETTLE=1 against registered adders.
module tb_add_operand_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       start1;
    int         mode;
    int         errors = 0;
    int         checks = 0;

    // main DUT, SETTLE=2
    logic [3:0] in1, in2, sum_in, fea, feb;
    logic       busy, done, pass, fev;
    logic [8:0] errc;
    logic [2:0] st;

    // SETTLE=1 DUTs with one-register and three-register delayed adders
    logic [3:0] a1, b1, s1, fa1, fb1;
    logic       busy1, done1, pass1, fev1;
    logic [8:0] errc1;
    logic [2:0] st1;
    logic [3:0] a3, b3, s3, fa3, fb3;
    logic       busy3, done3, pass3, fev3;
    logic [8:0] errc3;
    logic [2:0] st3;
    logic [3:0] d3_0, d3_1;

    always_comb begin
        sum_in = in1 + in2;
        if (mode == 1) sum_in = 4'd0;
        if (mode == 2 && in1 == 4'd15 && in2 == 4'd15) sum_in = 4'hF;
    end

    always @(posedge clk) begin
        s1   <= a1 + b1;
        d3_0 <= a3 + b3;
        d3_1 <= d3_0;
        s3   <= d3_1;
    end

    add_operand_driver #(.WIDTH(4), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2), .sum_in(sum_in),
        .busy(busy), .done(done), .pass(pass), .err_count(errc), .first_err_valid(fev),
        .first_err_a(fea), .first_err_b(feb), .dbg_state_o(st)
    );

    add_operand_driver #(.WIDTH(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in1(a1), .in2(b1), .sum_in(s1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(errc1), .first_err_valid(fev1),
        .first_err_a(fa1), .first_err_b(fb1), .dbg_state_o(st1)
    );

    add_operand_driver #(.WIDTH(4), .SETTLE(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in1(a3), .in2(b3), .sum_in(s3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(errc3), .first_err_valid(fev3),
        .first_err_a(fa3), .first_err_b(fb3), .dbg_state_o(st3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; mode = 0;
        tick(); tick();
        checks++;
        if ({in1, in2, busy, done, pass, errc, fev, fea, feb, st} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got in=%h/%h busy=%b done=%b pass=%b err=%0d fev=%b fe=%h/%h st=%0d, want all 0",
                     in1, in2, busy, done, pass, errc, fev, fea, feb, st);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (st !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got st=%0d busy=%b, want st=0 busy=0", st, busy);
        end
    endtask

    task automatic test_good_sweep();
        int c;
        mode = 0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_before_start: got %b, want 0", busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || st !== 3'd1) begin
            errors++;
            $display("FAIL busy_after_start: got busy=%b st=%0d, want busy=1 st=1", busy, st);
        end
        wait_done(1100, c);
        checks++;
        if (done !== 1'b1 || c != 1024) begin
            errors++;
            $display("FAIL good_latency: got done=%b cycles=%0d, want done=1 cycles=1024", done, c);
        end
        checks++;
        if (errc !== 9'd0 || pass !== 1'b1 || fev !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL good_result: got err=%0d pass=%b fev=%b busy=%b, want 0/1/0/0", errc, pass, fev, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || st !== 3'd0 || pass !== 1'b1 || in1 !== 4'd15 || in2 !== 4'd15) begin
            errors++;
            $display("FAIL good_hold: got done=%b st=%0d pass=%b in=%h/%h, want 0/0/1/f/f", done, st, pass, in1, in2);
        end
    endtask

    task automatic test_zero_sum();
        int c;
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1100, c);
        checks++;
        if (done !== 1'b1 || errc !== 9'd240 || pass !== 1'b0) begin
            errors++;
            $display("FAIL zero_sum_count: got done=%b err=%0d pass=%b, want 1/240/0", done, errc, pass);
        end
        checks++;
        if (fev !== 1'b1 || fea !== 4'd0 || feb !== 4'd1) begin
            errors++;
            $display("FAIL zero_sum_first: got fev=%b a=%0d b=%0d, want 1/0/1", fev, fea, feb);
        end
        tick();
    endtask

    task automatic test_single_fault();
        int c;
        mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (errc !== 9'd0 || fev !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL start_clears: got err=%0d fev=%b pass=%b, want 0/0/0", errc, fev, pass);
        end
        wait_done(1100, c);
        checks++;
        if (done !== 1'b1 || errc !== 9'd1 || pass !== 1'b0 || fev !== 1'b1 || fea !== 4'd15 || feb !== 4'd15) begin
            errors++;
            $display("FAIL single_fault: got done=%b err=%0d pass=%b fev=%b fe=%0d/%0d, want 1/1/0/1/15/15",
                     done, errc, pass, fev, fea, feb);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int c;
        bit seen_done;
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while ({in1, in2} !== 8'd50 && c < 400) begin
            tick();
            c++;
        end
        checks++;
        if ({in1, in2} !== 8'd50) begin
            errors++;
            $display("FAIL reach_pair50: got index=%0d, want 50", {in1, in2});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in1, in2, busy, done, pass, errc, fev, fea, feb, st} !== '0) begin
            errors++;
            $display("FAIL async_reset: got in=%h/%h busy=%b done=%b err=%0d fev=%b st=%0d, want all 0",
                     in1, in2, busy, done, errc, fev, st);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 1'b0) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (seen_done || done !== 1'b0 || st !== 3'd0) begin
            errors++;
            $display("FAIL reset_no_done: got seen_done=%b st=%0d, want 0/0", seen_done, st);
        end
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1100, c);
        checks++;
        if (done !== 1'b1 || c != 1024 || errc !== 9'd0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL fresh_sweep: got done=%b cycles=%0d err=%0d pass=%b, want 1/1024/0/1", done, c, errc, pass);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int cyc, done_cnt, first;
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; done_cnt = 0; first = -1;
        while (cyc < 1200) begin
            start = (cyc < 900 && (cyc % 7) == 3);
            tick();
            cyc++;
            if (done === 1'b1) begin
                done_cnt++;
                if (first < 0) first = cyc;
            end
        end
        start = 1'b0;
        checks++;
        if (done_cnt != 1 || first != 1024 || errc !== 9'd0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: got dones=%0d at=%0d err=%0d pass=%b, want 1/1024/0/1",
                     done_cnt, first, errc, pass);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        mode = 1;
        start = 1'b1;
        tick();
        wait_done(1100, c);
        checks++;
        if (done !== 1'b1 || errc !== 9'd240) begin
            errors++;
            $display("FAIL b2b_first: got done=%b err=%0d, want 1/240", done, errc);
        end
        mode = 0;
        tick();
        tick();
        checks++;
        if (st !== 3'd1 || busy !== 1'b1 || errc !== 9'd0 || fev !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL b2b_relaunch: got st=%0d busy=%b err=%0d fev=%b pass=%b, want 1/1/0/0/0",
                     st, busy, errc, fev, pass);
        end
        start = 1'b0;
        wait_done(1100, c);
        checks++;
        if (done !== 1'b1 || c != 1024 || errc !== 9'd0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got done=%b cycles=%0d err=%0d pass=%b, want 1/1024/0/1", done, c, errc, pass);
        end
        tick();
    endtask

    task automatic test_settle1();
        int c;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        c = 0;
        while (done1 !== 1'b1 && c < 1000) begin
            tick();
            c++;
        end
        checks++;
        if (done1 !== 1'b1 || c != 768 || errc1 !== 9'd0 || pass1 !== 1'b1) begin
            errors++;
            $display("FAIL settle1_reg1: got done=%b cycles=%0d err=%0d pass=%b, want 1/768/0/1", done1, c, errc1, pass1);
        end
        checks++;
        if (done3 !== 1'b1 || errc3 === 9'd0 || pass3 !== 1'b0) begin
            errors++;
            $display("FAIL settle1_reg3: got done=%b err=%0d pass=%b, want 1/nonzero/0", done3, errc3, pass3);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_zero_sum();
        test_single_fault();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        test_settle1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
